keypad_scanner: RTL and testbench
=================================

Name: keypad_scanner

Overview:
- Scans a 4x4 matrix keypad (PmodKYPD style) by driving one column low at a time and sampling four row inputs.
- Debounces each press and release, and emits the hex code of a key as a one-cycle strobe.
- Shifts the two most recent digits into an 8-bit entry register.
- It is the input-side counterpart of the anode-multiplexed 7-segment driver, and it replaces the slide switches as the operand source for the MAC datapath.

Parameters:
- SCAN_DIV, 100000: clk cycles per column slot, and the row-sample period (1 ms at 100 MHz).
- DEBOUNCE_SAMPLES, 4: number of consecutive matching samples needed to accept a press or a release.

Ports:
- clk  input  1  system clock, 100 MHz.
- rst_n  input  1  asynchronous, active-low reset.
- row  input  4  keypad rows; active-low with pull-ups; asynchronous to clk.
- col  output  4  keypad columns; one-hot active-low; idle columns are driven high.
- key_code  output  4  hex value of the last accepted key.
- key_valid  output  1  one-cycle strobe for each accepted press.
- key_held  output  1  high from acceptance of a press until its release is accepted.
- entry  output  8  shift register of the last two accepted digits.

Behaviour:
- Reset (asynchronous, rst_n=0): col=4'b1110, key_code=0, key_valid=0, key_held=0, entry=8'h00, state=SCAN, divider=0, debounce count=0.
- Row input: passes through a 2-flop synchronizer before any use.
- Divider: counts 0..SCAN_DIV-1 and wraps. tick is high when the divider equals SCAN_DIV-1. All row evaluation and column changes happen only on tick.
- Key map (row r, col c):
  - r0: 1 2 3 A
  - r1: 4 5 6 B
  - r2: 7 8 9 C
  - r3: 0 F E D
- "Single press" means exactly one synchronized row bit is low. Zero rows low, or two or more rows low, counts as no press.
- State SCAN:
  - On tick with a single press: capture the row pattern, hold col, go to DEBOUNCE with count=1.
  - On tick otherwise: rotate col to the next column (c3 wraps to c0).
- State DEBOUNCE (col frozen):
  - On tick, rows equal the captured pattern: count+1. When count reaches DEBOUNCE_SAMPLES, go to PRESSED.
  - On tick, rows mismatch: go to SCAN, advance col, report nothing.
- Entry to PRESSED:
  - key_valid=1 for exactly the one cycle after the accepting tick.
  - key_code updates in that same cycle.
  - entry <= {entry[3:0], code} in that same cycle.
  - key_held goes to 1.
- State PRESSED (col frozen):
  - Other keys, including keys in other columns, are ignored.
  - On tick with all rows high: go to RELEASE with count=1.
- State RELEASE:
  - On tick with all rows high: count+1. When count reaches DEBOUNCE_SAMPLES: key_held=0, go to SCAN, advance col.
  - On tick with any row low: go back to PRESSED. No new key_valid is issued.
- Latency: a press that is stable before detect tick T0 gives key_valid high (DEBOUNCE_SAMPLES-1)*SCAN_DIV + 1 cycles after T0.
- Bounce or glitch shorter than DEBOUNCE_SAMPLES samples produces no key_valid.
- Auto-repeat: none. A held key produces exactly one strobe.
- rst_n asserted in any state: all outputs return to their reset values immediately. Any partial debounce is discarded.
- Multiple keys in the same column during SCAN: ignored; scanning continues.
- key_code and entry hold their values until the next accepted press.

Decomposition:
- Package keypad_pkg:
  - state enum {SCAN, DEBOUNCE, PRESSED, RELEASE}.
  - COL_IDLE = 4'b1111.
  - 16-entry key map constant indexed by {row_idx, col_idx}.
  - one-hot-low to index helper function.
- Sub-module keypad_tick_gen: parameterised SCAN_DIV divider producing tick. It is reusable for display refresh.
- Synchronizer and FSM are implemented inline.

Test Plan (SCAN_DIV=4, DEBOUNCE_SAMPLES=3):
- Reset, then idle rows=4'hF for 40 cycles -> col cycles 1110, 1101, 1011, 0111, 1110 with 4 cycles per column; key_valid never asserts; entry=8'h00.
- Key '5' (row1 low while col1 active) held 100 cycles -> exactly one key_valid, 9 cycles after the detect tick; key_code=4'h5; key_held=1 until 3 release samples, then 0.
- Keys '9' then 'A', each cleanly pressed and released -> key_code=4'hA; entry=8'h9A; two strobes total.
- Key '7' with row low for only 2 samples, then bouncing high -> no key_valid; FSM returns to SCAN and col advances.
- Rows 0 and 2 low together on col0 -> no strobe. Then with 'D' held, press '1' as well -> no second strobe; a strobe occurs only after full release and a re-press.
- rst_n pulsed low during DEBOUNCE and again during PRESSED -> col=1110, key_held=0, entry=8'h00 asynchronously; no key_valid is emitted after release of reset until a new full debounce completes.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared definitions for the 4x4 matrix keypad scanner: FSM state codes,
// column constants, the key map and small decoding helpers.
package keypad_pkg;

    typedef logic [1:0] state_t;

    localparam state_t SCAN     = 2'd0;
    localparam state_t DEBOUNCE = 2'd1;
    localparam state_t PRESSED  = 2'd2;
    localparam state_t RELEASE  = 2'd3;

    // All columns released (driven high); the scan starts on column 0.
    localparam logic [3:0] COL_IDLE  = 4'b1111;
    localparam logic [3:0] COL_FIRST = COL_IDLE ^ 4'b0001;

    // Hex code of each key, indexed by {row_idx, col_idx}; entry 0 is listed last.
    localparam logic [15:0][3:0] KEY_MAP = {
        4'hD, 4'hE, 4'hF, 4'h0,
        4'hC, 4'h9, 4'h8, 4'h7,
        4'hB, 4'h6, 4'h5, 4'h4,
        4'hA, 4'h3, 4'h2, 4'h1
    };

    // Position of the low bit in a one-hot-low vector.
    function automatic logic [1:0] low_index(input logic [3:0] v);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (!v[i]) begin
                idx = 2'(i);
            end
        end
        return idx;
    endfunction

    // True when exactly one bit of the vector is low.
    function automatic logic single_low(input logic [3:0] v);
        return ($countones(~v) == 1);
    endfunction

endpackage

// File: rtl/keypad_tick_gen.sv
// Free-running divider producing a one-cycle tick every DIV clocks.
// Also usable as the refresh timebase of a multiplexed display.
module keypad_tick_gen #(
    parameter int DIV = 100000
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [W-1:0] LAST = W'(DIV - 1);

    logic [W-1:0] count;

    // Count 0..DIV-1 and wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (count == LAST) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

    assign tick = (count == LAST);

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: drives one column low at a time, debounces presses and
// releases of the row inputs, strobes the hex code of each accepted key and
// shifts the last two digits into an 8-bit entry register.
// DEBOUNCE_SAMPLES must be at least 2 (the detect sample counts as the first).
module keypad_scanner #(
    parameter int SCAN_DIV         = 100000,
    parameter int DEBOUNCE_SAMPLES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held,
    output logic [7:0] entry
);

    import keypad_pkg::*;

    localparam int CNT_W = $clog2(DEBOUNCE_SAMPLES + 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_SAMPLES - 1);

    logic             tick;
    logic [3:0]       row_meta;
    logic [3:0]       row_sync;
    logic [3:0]       row_cap;
    state_t           state;
    logic [CNT_W-1:0] deb_count;
    logic [3:0]       col_next;
    logic [3:0]       key_index;
    logic [3:0]       key_hex;
    logic             rows_idle;

    keypad_tick_gen #(
        .DIV(SCAN_DIV)
    ) u_tick_gen (
        .clk  (clk),
        .rst_n(rst_n),
        .tick (tick)
    );

    assign col_next  = {col[2:0], col[3]};
    assign key_index = {low_index(row_cap), low_index(col)};
    assign key_hex   = KEY_MAP[key_index];
    assign rows_idle = (row_sync == 4'hF);

    // Two-flop synchronizer for the asynchronous, pulled-up row inputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_meta <= 4'hF;
            row_sync <= 4'hF;
        end else begin
            row_meta <= row;
            row_sync <= row_meta;
        end
    end

    // Scan / debounce / hold / release FSM, evaluated only on the sample tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= SCAN;
            col       <= COL_FIRST;
            row_cap   <= 4'hF;
            deb_count <= '0;
            key_code  <= 4'h0;
            key_valid <= 1'b0;
            key_held  <= 1'b0;
            entry     <= 8'h00;
        end else begin
            key_valid <= 1'b0;
            if (tick) begin
                case (state)
                    SCAN: begin
                        if (single_low(row_sync)) begin
                            row_cap   <= row_sync;
                            deb_count <= CNT_ONE;
                            state     <= DEBOUNCE;
                        end else begin
                            col <= col_next;
                        end
                    end
                    DEBOUNCE: begin
                        if (row_sync == row_cap) begin
                            if (deb_count == CNT_LAST) begin
                                deb_count <= '0;
                                key_valid <= 1'b1;
                                key_code  <= key_hex;
                                entry     <= {entry[3:0], key_hex};
                                key_held  <= 1'b1;
                                state     <= PRESSED;
                            end else begin
                                deb_count <= deb_count + 1'b1;
                            end
                        end else begin
                            deb_count <= '0;
                            col       <= col_next;
                            state     <= SCAN;
                        end
                    end
                    PRESSED: begin
                        if (rows_idle) begin
                            deb_count <= CNT_ONE;
                            state     <= RELEASE;
                        end
                    end
                    RELEASE: begin
                        if (rows_idle) begin
                            if (deb_count == CNT_LAST) begin
                                deb_count <= '0;
                                key_held  <= 1'b0;
                                col       <= col_next;
                                state     <= SCAN;
                            end else begin
                                deb_count <= deb_count + 1'b1;
                            end
                        end else begin
                            deb_count <= '0;
                            state     <= PRESSED;
                        end
                    end
                    default: begin
                        state <= SCAN;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner with a behavioural keypad matrix
// and a scoreboard of expected key strobes.
module tb_keypad_scanner;

    localparam int SCAN_DIV         = 4;
    localparam int DEBOUNCE_SAMPLES = 3;

    // Key indices into keys_down, {row, col}.
    localparam int K1 = 0;
    localparam int K5 = 5;
    localparam int K7 = 8;
    localparam int K9 = 10;
    localparam int KA = 3;
    localparam int KD = 15;

    typedef struct packed {
        logic [3:0] code;
        logic [7:0] entry;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] row;
    logic [3:0] col;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;
    logic [7:0] entry;

    logic [15:0] keys_down = '0;
    logic [7:0]  exp_entry = 8'h00;
    exp_t        sb[$];

    int tests_run    = 0;
    int tests_failed = 0;
    int strobe_count = 0;

    keypad_scanner #(
        .SCAN_DIV        (SCAN_DIV),
        .DEBOUNCE_SAMPLES(DEBOUNCE_SAMPLES)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .row      (row),
        .col      (col),
        .key_code (key_code),
        .key_valid(key_valid),
        .key_held (key_held),
        .entry    (entry)
    );

    always #5 clk = ~clk;

    // Matrix model: a pressed key pulls its row low while its column is driven low.
    always_comb begin
        row = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (keys_down[r*4+c] && !col[c]) begin
                    row[r] = 1'b0;
                end
            end
        end
    end

    task automatic check_output(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Press a key that must be accepted and record the expected strobe.
    task automatic apply_stimulus(input int idx, input logic [3:0] code);
        keys_down[idx] = 1'b1;
        exp_entry = {exp_entry[3:0], code};
        sb.push_back('{code: code, entry: exp_entry});
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_strobe(input string tag, input int limit);
        int start;
        int n;
        start = strobe_count;
        n = 0;
        while (strobe_count == start && n < limit) begin
            @(negedge clk);
            n++;
        end
        check_output(tag, 32'(strobe_count > start), 32'd1);
    endtask

    task automatic wait_release(input string tag, input int limit);
        int n;
        n = 0;
        while (key_held && n < limit) begin
            @(negedge clk);
            n++;
        end
        check_output(tag, 32'(key_held), 32'd0);
    endtask

    // Returns on the first negedge at which col has just become target.
    task automatic wait_col(input logic [3:0] target, input int limit);
        int n;
        n = 0;
        while (col == target && n < limit) begin
            @(negedge clk);
            n++;
        end
        while (col != target && n < limit) begin
            @(negedge clk);
            n++;
        end
        check_output("wait_col", 32'(col), 32'(target));
    endtask

    task automatic press_and_release(input string tag, input int idx, input logic [3:0] code);
        apply_stimulus(idx, code);
        wait_strobe(tag, 60);
        cycles(10);
        keys_down[idx] = 1'b0;
        wait_release(tag, 40);
        cycles(4);
    endtask

    // Scoreboard: each strobe pops and checks the oldest expected key.
    always @(negedge clk) begin
        if (rst_n && key_valid) begin
            strobe_count++;
            if (sb.size() == 0) begin
                check_output("spurious_strobe", 32'(key_valid), 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check_output("strobe_code", 32'(key_code), 32'(e.code));
                check_output("strobe_entry", 32'(entry), 32'(e.entry));
                check_output("strobe_held", 32'(key_held), 32'd1);
            end
        end
    end

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int         lat;
        int         s;
        int         run;
        bit         first;
        logic [3:0] prev;

        // Reset values.
        #23;
        check_output("rst_col", 32'(col), 32'h0000000E);
        check_output("rst_code", 32'(key_code), 32'd0);
        check_output("rst_valid", 32'(key_valid), 32'd0);
        check_output("rst_held", 32'(key_held), 32'd0);
        check_output("rst_entry", 32'(entry), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Idle scan: columns rotate with a 4-cycle slot each.
        prev  = col;
        run   = 0;
        first = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (col == prev) begin
                run++;
            end else begin
                check_output("col_rotate", 32'(col), 32'({prev[2:0], prev[3]}));
                if (!first) check_output("col_slot", 32'(run), 32'(SCAN_DIV));
                first = 1'b0;
                run   = 1;
                prev  = col;
            end
        end
        check_output("idle_entry", 32'(entry), 32'd0);
        check_output("idle_strobes", 32'(strobe_count), 32'd0);

        // Key '5' held: one strobe, fixed latency from the detect tick.
        wait_col(4'b1110, 40);
        s = strobe_count;
        apply_stimulus(K5, 4'h5);
        wait_col(4'b1101, 40);
        lat = 1;
        while (!key_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check_output("latency_5", 32'(lat), 32'((DEBOUNCE_SAMPLES - 1) * SCAN_DIV + 1 + SCAN_DIV));
        cycles(100);
        check_output("held_5", 32'(key_held), 32'd1);
        check_output("code_5", 32'(key_code), 32'h5);
        check_output("strobes_5", 32'(strobe_count - s), 32'd1);
        keys_down[K5] = 1'b0;
        cycles(6);
        check_output("held_release_wait", 32'(key_held), 32'd1);
        cycles(14);
        check_output("released_5", 32'(key_held), 32'd0);
        cycles(4);

        // Keys '9' then 'A'.
        s = strobe_count;
        press_and_release("strobe_9", K9, 4'h9);
        press_and_release("strobe_A", KA, 4'hA);
        check_output("code_A", 32'(key_code), 32'hA);
        check_output("entry_9A", 32'(entry), 32'h9A);
        check_output("strobes_9A", 32'(strobe_count - s), 32'd2);

        // Key '7' low for only two samples: rejected, scan resumes.
        wait_col(4'b1110, 40);
        s = strobe_count;
        keys_down[K7] = 1'b1;
        for (int k = 2; k <= 13; k++) begin
            @(negedge clk);
            if (k == 7) keys_down[K7] = 1'b0;
            if (k == 12) check_output("bounce_col_frozen", 32'(col), 32'h0000000E);
        end
        check_output("bounce_col_advance", 32'(col), 32'h0000000D);
        check_output("bounce_strobes", 32'(strobe_count - s), 32'd0);
        cycles(8);

        // Two rows low in column 0: ignored, scanning continues.
        wait_col(4'b1110, 40);
        s = strobe_count;
        keys_down[K1] = 1'b1;
        keys_down[K7] = 1'b1;
        cycles(6);
        check_output("multi_row_scan", 32'(col), 32'h0000000D);
        cycles(34);
        check_output("multi_row_strobes", 32'(strobe_count - s), 32'd0);
        keys_down = '0;
        cycles(8);

        // 'D' held, then '1' pressed too: no second strobe until full release.
        apply_stimulus(KD, 4'hD);
        wait_strobe("strobe_D", 60);
        s = strobe_count;
        keys_down[K1] = 1'b1;
        cycles(40);
        check_output("held_D", 32'(key_held), 32'd1);
        keys_down[K1] = 1'b0;
        cycles(20);
        check_output("no_second_strobe", 32'(strobe_count - s), 32'd0);
        keys_down[KD] = 1'b0;
        wait_release("release_D", 40);
        cycles(4);
        press_and_release("strobe_D2", KD, 4'hD);
        check_output("entry_DD", 32'(entry), 32'hDD);

        // Reset during DEBOUNCE, key still held afterwards.
        wait_col(4'b1110, 40);
        keys_down[K5] = 1'b1;
        wait_col(4'b1101, 40);
        cycles(6);
        #2 rst_n = 1'b0;
        #1;
        check_output("rst_deb_col", 32'(col), 32'h0000000E);
        check_output("rst_deb_held", 32'(key_held), 32'd0);
        check_output("rst_deb_entry", 32'(entry), 32'd0);
        check_output("rst_deb_valid", 32'(key_valid), 32'd0);
        sb.delete();
        exp_entry = 8'h00;
        @(negedge clk);
        rst_n = 1'b1;
        exp_entry = {exp_entry[3:0], 4'h5};
        sb.push_back('{code: 4'h5, entry: exp_entry});
        s = strobe_count;
        cycles(12);
        check_output("no_early_strobe", 32'(strobe_count - s), 32'd0);
        wait_strobe("strobe_after_rst", 40);

        // Reset during PRESSED.
        cycles(10);
        check_output("pressed_before_rst", 32'(key_held), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check_output("rst_pr_col", 32'(col), 32'h0000000E);
        check_output("rst_pr_held", 32'(key_held), 32'd0);
        check_output("rst_pr_entry", 32'(entry), 32'd0);
        check_output("rst_pr_code", 32'(key_code), 32'd0);
        sb.delete();
        exp_entry = 8'h00;
        keys_down = '0;
        @(negedge clk);
        rst_n = 1'b1;
        s = strobe_count;
        cycles(40);
        check_output("idle_after_rst", 32'(strobe_count - s), 32'd0);
        check_output("entry_after_rst", 32'(entry), 32'd0);
        check_output("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
